config_loader: RTL
==================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the address field width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data field width in bits.
REQ-003 SHALL have parameter CFG_REG, default 8, the number of neuron configuration registers; addresses below CFG_REG are configuration, all others are synaptic.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset (asserted when 0).
REQ-006 SHALL have port frame, input, 1 bit, high for the duration of one serial write frame.
REQ-007 SHALL have port sdi, input, 1 bit, serial data, MSB first.
REQ-008 SHALL have port sdi_vld, input, 1 bit; sdi is sampled only in cycles where sdi_vld=1 and frame=1.
REQ-009 SHALL have port syn_ready, input, 1 bit, synaptic memory accepts a write.
REQ-010 SHALL have ports wr_addr (output, ADDR_WIDTH) and wr_data (output, DATA_WIDTH), the shared write address and write data.
REQ-011 SHALL have ports cfg_wr_en and syn_wr_en, outputs, 1 bit each, the configuration and synaptic write strobes.
REQ-012 SHALL have port busy, output, 1 bit, a frame is being shifted in or a write is pending.
REQ-013 SHALL have ports err_abort and err_overrun, outputs, 1 bit each, sticky error flags.
REQ-014 SHALL have port wr_count, output, 16 bits, the number of committed writes.

Function
REQ-015 Frame format SHALL be ADDR_WIDTH address bits followed by DATA_WIDTH data bits, MSB first, for a total of FRAME_BITS=ADDR_WIDTH+DATA_WIDTH.
REQ-016 The FSM SHALL have states IDLE, SHIFT, WRITE and DRAIN.
REQ-017 IDLE->SHIFT SHALL occur on the first cycle with frame=1 and sdi_vld=1; that bit is captured and bit_cnt becomes 1.
REQ-018 In SHIFT, each valid bit SHALL shift into a FRAME_BITS register and increment bit_cnt; when bit_cnt reaches FRAME_BITS, the next state SHALL be WRITE.
REQ-019 In SHIFT, frame=0 before FRAME_BITS bits SHALL discard the partial frame, set err_abort, and return to IDLE with no write.
REQ-020 In WRITE with address < CFG_REG, cfg_wr_en SHALL pulse high for exactly one cycle; the FSM then goes to DRAIN.
REQ-021 In WRITE with address >= CFG_REG, syn_wr_en SHALL be held high until a cycle with syn_ready=1, which is the commit cycle; the FSM then goes to DRAIN.
REQ-022 wr_addr and wr_data SHALL be stable and valid in every cycle that either strobe is high; cfg_wr_en and syn_wr_en SHALL never be high together.
REQ-023 Latency SHALL be: cfg_wr_en asserts in the cycle after the clock edge that samples the last frame bit.
REQ-024 DRAIN SHALL wait for frame=0, then go to IDLE; extra valid bits received in DRAIN SHALL set err_overrun and SHALL be ignored.
REQ-025 Valid bits received in WRITE SHALL set err_overrun and SHALL be ignored.
REQ-026 wr_count SHALL increment by 1 on each committed write and wrap from 0xFFFF to 0.
REQ-027 err_abort and err_overrun SHALL remain set until reset.
REQ-028 busy SHALL be 1 in SHIFT, WRITE and DRAIN, and 0 in IDLE.

Reset
REQ-029 Asserting rst=0 SHALL immediately force the FSM to IDLE and clear bit_cnt, the shift register, wr_addr, wr_data, cfg_wr_en, syn_wr_en, busy, err_abort, err_overrun and wr_count to 0.
REQ-030 Reset asserted in the middle of a frame or during a WRITE stall SHALL drop that write without any strobe.
REQ-031 After rst returns to 1, the block SHALL ignore an in-progress frame until frame has been seen low for at least one cycle.

Structure
REQ-032 The FSM state encoding, a FRAME_BITS function and the WR_COUNT_W=16 constant SHALL live in a shared package, loader_pkg.
REQ-033 One sub-module, sipo_shift (a serial-in parallel-out register with bit counter and full flag), SHALL be instantiated; the FSM, write routing and error flags SHALL stay in config_loader.
REQ-034 The cfg_wr_en, wr_addr and wr_data outputs SHALL connect directly to the wr_en, wr_addr and wr_data inputs of the neuron configuration decoder.

Verification
REQ-035 Config write: frame addr=2, data=0x0000_0005 -> one cfg_wr_en pulse with wr_addr=2 and wr_data=5, wr_count=1, syn_wr_en stays 0.
REQ-036 Synaptic stall: frame addr=0x100, data=0xDEADBEEF, syn_ready=0 for 5 cycles then 1 -> syn_wr_en high for 6 cycles, commit on the 6th, busy until frame=0.
REQ-037 Abort: frame drops after 40 of 64 bits -> err_abort=1, no strobe, wr_count unchanged, and the next full frame still writes correctly.
REQ-038 Overrun: 3 extra valid bits after bit 64 with frame held high -> err_overrun=1 and exactly one write.
REQ-039 Reset mid-frame: rst=0 at bit 20, released, frame still high -> no write until frame drops and a new frame completes.
REQ-040 Boundary: addr=7 routes to config and addr=8 routes to synaptic; 0xFFFF writes followed by one more -> wr_count=0.

Source files
------------

// File: rtl/loader_pkg.sv
// loader_pkg: types and constants shared by the config loader.
// FSM encoding, frame length helper and write-counter width.
package loader_pkg;

   localparam int WR_COUNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_WRITE = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   function automatic int frame_bits(input int aw, input int dw);
      return aw + dw;
   endfunction

endpackage

// File: rtl/sipo_shift.sv
// sipo_shift: serial-in parallel-out register, MSB first.
// Counts captured bits; full marks a complete word.
module sipo_shift #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         shift_en,
   input  logic         sdi,
   output logic [W-1:0] data,
   output logic         last,
   output logic         full
);

   localparam int CW = $clog2(W + 1);

   logic [CW-1:0] cnt;

   assign last = shift_en && (cnt == CW'(W - 1));
   assign full = (cnt == CW'(W));

   // clr restarts the count but keeps the captured word visible
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data <= '0;
         cnt  <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (shift_en) begin
         data <= {data[W-2:0], sdi};
         cnt  <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/config_loader.sv
// config_loader: serial frame receiver that routes one write
// to neuron config or synaptic memory per frame.
module config_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CFG_REG    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame,
   input  logic                  sdi,
   input  logic                  sdi_vld,
   input  logic                  syn_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  cfg_wr_en,
   output logic                  syn_wr_en,
   output logic                  busy,
   output logic                  err_abort,
   output logic                  err_overrun,
   output logic [WR_COUNT_W-1:0] wr_count
);

   localparam int FB = frame_bits(ADDR_WIDTH, DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] CFG_LIM =
      ADDR_WIDTH'(CFG_REG);

   state_t                  state;
   logic                    armed;
   logic [FB-1:0]           sr;
   logic                    last;
   logic                    full;
   logic                    start;
   logic                    shift_en;
   logic                    abort;
   logic                    clr;
   logic [ADDR_WIDTH-1:0]   addr_nxt;

   // armed blocks a frame that was already running at reset release
   assign start    = (state == ST_IDLE) && armed
                     && frame && sdi_vld;
   assign shift_en = start
                     || ((state == ST_SHIFT) && frame && sdi_vld);
   assign abort    = (state == ST_SHIFT) && !frame;
   assign clr      = abort || full;

   // address as it will look once the final bit lands
   assign addr_nxt = sr[FB-2 -: ADDR_WIDTH];
   assign wr_addr  = sr[FB-1 -: ADDR_WIDTH];
   assign wr_data  = sr[DATA_WIDTH-1:0];

   sipo_shift #(
      .W(FB)
   ) u_sipo (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .shift_en (shift_en),
      .sdi      (sdi),
      .data     (sr),
      .last     (last),
      .full     (full)
   );

   // frame FSM, write strobes, commit counter and sticky errors
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         armed       <= 1'b0;
         cfg_wr_en   <= 1'b0;
         syn_wr_en   <= 1'b0;
         busy        <= 1'b0;
         err_abort   <= 1'b0;
         err_overrun <= 1'b0;
         wr_count    <= '0;
      end else begin
         if (!frame) armed <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_SHIFT;
                  busy  <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (abort) begin
                  err_abort <= 1'b1;
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
               end else if (last) begin
                  if (addr_nxt < CFG_LIM) cfg_wr_en <= 1'b1;
                  else                    syn_wr_en <= 1'b1;
                  state <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (frame && sdi_vld) err_overrun <= 1'b1;
               if (cfg_wr_en) begin
                  cfg_wr_en <= 1'b0;
                  wr_count  <= wr_count + 1'b1;
                  state     <= ST_DRAIN;
               end else if (syn_ready) begin
                  syn_wr_en <= 1'b0;
                  wr_count  <= wr_count + 1'b1;
                  state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!frame) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (sdi_vld) begin
                  err_overrun <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
